// File: rtl/cu_pkg.sv
// cu_pkg: shared halt-cause encodings, fetch step index and control-word write-enable layout
package cu_pkg;
  localparam int CU_CW_WIDTH = 34;
  localparam int STEP_FETCH = 0;
  localparam int CW_REG_WRITE = 0;
  localparam int CW_MEM_WRITE = 1;
  localparam int CW_STATUS_LOAD = 2;
  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_BAD_NS = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } cause_e;
  // Builds a WE_MASK from the individual write-enable selections
  function automatic logic [CU_CW_WIDTH-1:0] we_mask(input logic reg_write, input logic mem_write,
                                                     input logic status_load);
    we_mask = '0;
    we_mask[CW_REG_WRITE] = reg_write;
    we_mask[CW_MEM_WRITE] = mem_write;
    we_mask[CW_STATUS_LOAD] = status_load;
  endfunction
endpackage

// File: rtl/cu_wait_timer.sv
// cu_wait_timer: counts consecutive stalled cycles and flags a timeout on the WAIT_LIMIT-th one
// Ports: clock, reset (async active-low), stall (waiting on memory), clear (step changes this edge),
//        timeout (this edge is the WAIT_LIMIT-th consecutive stalled edge; never set when WAIT_LIMIT=0)
module cu_wait_timer #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic stall,
  input  logic clear,
  output logic timeout
);
  localparam int W = WAIT_LIMIT > 0 ? $clog2(WAIT_LIMIT + 1) : 1;
  logic [W-1:0] cnt;
  // cnt holds the stalled edges already seen, so the limit is hit when one more would reach it
  assign timeout = (WAIT_LIMIT != 0) && stall && (cnt == W'(WAIT_LIMIT - 1));
  always_ff @(posedge clock or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (stall && !clear) ? cnt + 1'b1 : '0;
endmodule

// File: rtl/cu_step_sequencer.sv
// cu_step_sequencer: multi-cycle fetch/execute step sequencer with stall, WE gating, halt/trap and retire count
// Ports: clock, reset (async active-low); instr_in, mem_ready, cw_in, ns_in, mem_access, illegal, resume in;
//        step, ir, ir_load, cw_out (gated control word), stall, halted, halt_cause, retired out
module cu_step_sequencer
  import cu_pkg::*;
#(
  parameter int CW_WIDTH = CU_CW_WIDTH,
  parameter int N_STEPS = 4,
  parameter int STEP_W = 2,
  parameter logic [CW_WIDTH-1:0] WE_MASK = '0,
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         instr_in,
  input  logic                mem_ready,
  input  logic [CW_WIDTH-1:0] cw_in,
  input  logic [STEP_W-1:0]   ns_in,
  input  logic                mem_access,
  input  logic                illegal,
  input  logic                resume,
  output logic [STEP_W-1:0]   step,
  output logic [31:0]         ir,
  output logic                ir_load,
  output logic [CW_WIDTH-1:0] cw_out,
  output logic                stall,
  output logic                halted,
  output logic [1:0]          halt_cause,
  output logic [CNT_W-1:0]    retired
);
  logic [STEP_W-1:0] step_nxt;
  logic [31:0] ir_nxt;
  logic halted_nxt;
  cause_e cause, cause_nxt;
  logic [CNT_W-1:0] retired_nxt;
  logic fetch, bad_ns, timeout;
  assign fetch = step == STEP_W'(STEP_FETCH);
  assign bad_ns = 32'(ns_in) >= N_STEPS;
  // Fetch always touches memory; a halted sequencer sits at step 0 but is not waiting
  assign stall = reset && (fetch ? (!mem_ready && !halted) : (mem_access && !mem_ready));
  assign ir_load = reset && fetch && !halted && mem_ready;
  assign cw_out = (!reset || stall || halted || illegal) ? cw_in & ~WE_MASK : cw_in;
  assign halt_cause = cause;
  cu_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait (
    .clock(clock),
    .reset(reset),
    .stall(stall),
    .clear(step_nxt != step),
    .timeout(timeout)
  );
  always_comb begin
    step_nxt = step;
    ir_nxt = ir;
    halted_nxt = halted;
    cause_nxt = cause;
    retired_nxt = retired;
    if (halted) begin
      if (resume) begin
        halted_nxt = 1'b0;
        cause_nxt = CAUSE_NONE;
      end
    end else if (fetch) begin
      if (mem_ready) begin
        ir_nxt = instr_in;
        step_nxt = STEP_W'(1);
      end else if (timeout) begin
        halted_nxt = 1'b1;
        cause_nxt = CAUSE_TIMEOUT;
      end
    end else if (illegal) begin
      halted_nxt = 1'b1;
      cause_nxt = CAUSE_ILLEGAL;
      step_nxt = STEP_W'(STEP_FETCH);
    end else if (bad_ns) begin
      halted_nxt = 1'b1;
      cause_nxt = CAUSE_BAD_NS;
      step_nxt = STEP_W'(STEP_FETCH);
    end else if (stall) begin
      if (timeout) begin
        halted_nxt = 1'b1;
        cause_nxt = CAUSE_TIMEOUT;
        step_nxt = STEP_W'(STEP_FETCH);
      end
    end else begin
      step_nxt = ns_in;
      retired_nxt = ns_in == '0 ? retired + 1'b1 : retired;
    end
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      step <= '0;
      ir <= '0;
      halted <= 1'b0;
      cause <= CAUSE_NONE;
      retired <= '0;
    end else begin
      step <= step_nxt;
      ir <= ir_nxt;
      halted <= halted_nxt;
      cause <= cause_nxt;
      retired <= retired_nxt;
    end
endmodule

// File: doc/cu_step_sequencer.md
Name: cu_step_sequencer

Overview:
- Parametrised multi-cycle step sequencer for the ARM_64 control unit; successor to the fixed IF/EX0/EX1/EX2 2-bit state register.
- Owns the step register, the instruction register, memory-wait stalling, write-enable gating of the control word, halt/trap handling and a retired-instruction counter.
- Decode logic stays external: it consumes `step` and `ir` and returns the step's control word and next-step field.

Parameters:
- CW_WIDTH, 34, width of control word passed through to the datapath.
- N_STEPS, 4, total steps including fetch (step 0); legal range 2..16.
- STEP_W, 2, width of step index; must be >= clog2(N_STEPS).
- WE_MASK, 34'h0, CW_WIDTH-bit mask of write-enable bits (RegWrite, mem_write, status load) forced to 0 when gated.
- WAIT_LIMIT, 255, max consecutive memory-wait cycles before timeout trap; 0 disables timeout.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- instr_in  in  32  instruction word from memory data bus.
- mem_ready  in  1  memory completes current access this cycle.
- cw_in  in  CW_WIDTH  decoder control word for current step/ir.
- ns_in  in  STEP_W  decoder next-step field; 0 = return to fetch.
- mem_access  in  1  current execute step performs a memory access.
- illegal  in  1  decoder flags ir as unimplemented.
- resume  in  1  leave halt state.
- step  out  STEP_W  current step index (0 = fetch).
- ir  out  32  instruction register.
- ir_load  out  1  ir captures instr_in at this edge.
- cw_out  out  CW_WIDTH  gated control word to datapath.
- stall  out  1  current step waiting on memory.
- halted  out  1  sequencer trapped.
- halt_cause  out  2  0 none, 1 illegal, 2 bad next-step, 3 memory timeout.
- retired  out  CNT_W  instructions completed.

Behaviour:
- Reset (reset=0, asynchronous): step=0, ir=0, halted=0, halt_cause=0, retired=0, wait counter=0.
  - Combinational outputs under reset: stall=0, ir_load=0, cw_out = cw_in & ~WE_MASK.
- stall:
  - Fetch: stall = !mem_ready & !halted.
  - Execute: stall = mem_access & !mem_ready.
- Gating: cw_out = cw_in & ~WE_MASK when stall | halted | illegal, otherwise cw_out = cw_in. Combinational, zero latency.
- Fetch (step 0, not halted):
  - Fetch is always a memory access; ns_in, illegal and mem_access are ignored.
  - mem_ready=1: ir_load=1, ir<=instr_in, step<=1.
  - mem_ready=0: hold step and ir.
- Execute (step k, 1 <= k < N_STEPS), priority order:
  1. illegal=1: halted<=1, cause<=1, step<=0.
  2. ns_in >= N_STEPS: halted<=1, cause<=2, step<=0.
  3. stall: hold step.
  4. Otherwise step<=ns_in; if ns_in==0, retired<=retired+1 (wraps modulo 2^CNT_W).
- Wait counter:
  - Increments each stalled cycle; clears on any step change or when not stalled.
  - If WAIT_LIMIT != 0 and the counter reaches WAIT_LIMIT while still stalled: halted<=1, cause<=3, step<=0 at that edge.
  - Applies to both fetch and execute.
- Halt: step held at 0, ir held, ir_load=0, retired frozen.
  - resume=1 while halted: halted<=0, cause<=0; fetch starts the next cycle.
  - resume is ignored when not halted.
- A single-step instruction (ns_in=0 at step 1) retires in 2 cycles with zero wait.
- reset asserted mid-instruction aborts immediately; no partial retire is counted.

Decomposition:
- Shared package `cu_pkg`:
  - halt_cause encodings (CAUSE_NONE/ILLEGAL/BAD_NS/TIMEOUT).
  - STEP_FETCH=0.
  - Default CW_WIDTH.
  - Control-word field offsets used to build WE_MASK.
- One sub-module `cu_wait_timer`: WAIT_LIMIT-bounded stall counter with a timeout output. All other logic stays in the top module.

Test Plan:
1. Reset, then fetch with mem_ready=1, instr_in=32'h8B020020, ns_in=0 at step 1 → ir=32'h8B020020 after edge 1, step returns to 0 after edge 2, retired=1.
2. Three-step instruction (ns 1→2→3→0), WE_MASK=34'h1, mem_access=1 at step 2 with mem_ready low for 3 cycles → stall=1 for 3 cycles, cw_out[0]=0 during stall, step held at 2, retired increments after 7 total cycles.
3. illegal=1 at step 1 with cw_in all ones → halted=1, halt_cause=1, cw_out=~WE_MASK; pulse resume → halted=0, cause=0, next cycle is fetch.
4. N_STEPS=3, ns_in=3 at step 1 → halted=1, halt_cause=2, step=0, retired unchanged.
5. WAIT_LIMIT=4, mem_ready held low in fetch → halted=1, halt_cause=3 at the 4th stalled edge; ir unchanged.
6. CNT_W=4, retire 17 single-step instructions → retired=1 (wrap); assert reset mid-step 1 → all registers 0 immediately (asynchronously, without a clock edge).
